// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer index scheduler between the camera DDR writer and the HDMI display reader.
// state | meaning: IDLE=disabled, ARM=wait for frame edge, WRITE=writer filling wr_buf_idx, COMMIT=publish frame
module frame_buffer_scheduler #(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE   = 32'h0004_0000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_done,
    input  logic        writer_done,
    input  logic        rd_frame_start,
    output logic [31:0] wr_base_addr,
    output logic [1:0]  wr_buf_idx,
    output logic [31:0] rd_base_addr,
    output logic [1:0]  rd_buf_idx,
    output logic        rd_valid,
    output logic [15:0] frames_written,
    output logic [15:0] frames_dropped,
    output logic        err_timeout,
    output logic [1:0]  sched_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        WRITE  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    function automatic logic [31:0] buf_addr(input logic [1:0] idx);
        return BASE_ADDR + ({30'd0, idx} * FRAME_STRIDE);
    endfunction

    function automatic logic [1:0] free_idx(input logic [1:0] a, input logic [1:0] b);
        if (a != 2'd0 && b != 2'd0)      return 2'd0;
        else if (a != 2'd1 && b != 2'd1) return 2'd1;
        else                             return 2'd2;
    endfunction

    state_t      state_q, state_d;
    logic        frame_done_d1_q;
    logic [1:0]  wr_idx_q, wr_idx_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic [1:0]  latest_idx_q, latest_idx_d;
    logic        latest_valid_q, latest_valid_d;
    logic        rd_valid_q, rd_valid_d;
    logic [15:0] written_q, written_d;
    logic [15:0] dropped_q, dropped_d;
    logic        err_q, err_d;
    logic [23:0] timer_q, timer_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        fe;

    assign fe = frame_done & ~frame_done_d1_q;

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        latest_idx_d   = latest_idx_q;
        latest_valid_d = latest_valid_q;
        rd_valid_d     = rd_valid_q;
        written_d      = written_q;
        dropped_d      = dropped_q;
        err_d          = err_q;
        timer_d        = timer_q;

        // Reader swap runs in every state and always sees the pre-commit latest buffer.
        if (rd_frame_start && latest_valid_q && (latest_idx_q != rd_idx_q)) begin
            rd_idx_d   = latest_idx_q;
            rd_valid_d = 1'b1;
        end

        // Timer counts down from TIMEOUT_CYCLES-1; terminal count 0 marks the last allowed WRITE cycle.
        case (state_q)
            IDLE: begin
                if (enable) state_d = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fe) begin
                    state_d = WRITE;
                    timer_d = TIMEOUT_CYCLES - 24'd1;
                end
            end
            WRITE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (writer_done) begin
                    state_d = COMMIT;
                end else if (timer_q == 24'd0) begin
                    err_d     = 1'b1;
                    dropped_d = dropped_q + 16'd1;
                    state_d   = ARM;
                end else if (fe) begin
                    dropped_d = dropped_q + 16'd1;
                    timer_d   = TIMEOUT_CYCLES - 24'd1;
                end else begin
                    timer_d = timer_q - 24'd1;
                end
            end
            COMMIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    latest_idx_d   = wr_idx_q;
                    latest_valid_d = 1'b1;
                    written_d      = written_q + 16'd1;
                    wr_idx_d       = free_idx(wr_idx_q, rd_idx_d);
                    timer_d        = TIMEOUT_CYCLES - 24'd1;
                    state_d        = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_addr_d = buf_addr(wr_idx_d);
        rd_addr_d = buf_addr(rd_idx_d);
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q         <= IDLE;
            frame_done_d1_q <= 1'b0;
            wr_idx_q        <= 2'd0;
            rd_idx_q        <= 2'd2;
            latest_idx_q    <= 2'd0;
            latest_valid_q  <= 1'b0;
            rd_valid_q      <= 1'b0;
            written_q       <= 16'd0;
            dropped_q       <= 16'd0;
            err_q           <= 1'b0;
            timer_q         <= 24'd0;
            wr_addr_q       <= buf_addr(2'd0);
            rd_addr_q       <= buf_addr(2'd2);
        end else begin
            state_q         <= state_d;
            frame_done_d1_q <= frame_done;
            wr_idx_q        <= wr_idx_d;
            rd_idx_q        <= rd_idx_d;
            latest_idx_q    <= latest_idx_d;
            latest_valid_q  <= latest_valid_d;
            rd_valid_q      <= rd_valid_d;
            written_q       <= written_d;
            dropped_q       <= dropped_d;
            err_q           <= err_d;
            timer_q         <= timer_d;
            wr_addr_q       <= wr_addr_d;
            rd_addr_q       <= rd_addr_d;
        end
    end

    assign wr_base_addr   = wr_addr_q;
    assign wr_buf_idx     = wr_idx_q;
    assign rd_base_addr   = rd_addr_q;
    assign rd_buf_idx     = rd_idx_q;
    assign rd_valid       = rd_valid_q;
    assign frames_written = written_q;
    assign frames_dropped = dropped_q;
    assign err_timeout    = err_q;
    assign sched_state    = state_q;

endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Triple-buffer scheduler for the camera → DDR → HDMI frame path. It owns the frame-buffer indices, selecting which DDR frame buffer the stream-to-memory writer fills and which the display reader scans out, so the two never touch the same buffer. It publishes a buffer only after the writer reports that the frame is complete, and it counts committed and dropped frames. It sits in the 100 MHz AXI clock domain, between the camera frame-done strobe, the writer's `writer_done`, and the reader's frame-start strobe.

## Interface
Parameters:
- `BASE_ADDR`, 32'h1000_0000, DDR byte address of buffer 0.
- `FRAME_STRIDE`, 32'h0004_0000, byte distance between buffers; must be ≥ 153600 (320×240×2).
- `TIMEOUT_CYCLES`, 24'd4_000_000, maximum cycles in WRITE without `writer_done`.

Ports:
- `clk_100Mhz`  in  1  the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  scheduler run enable.
- `frame_done`  in  1  camera frame-done level; the block edge-detects it internally.
- `writer_done`  in  1  one-cycle pulse from the writer after the last burst's B response.
- `rd_frame_start`  in  1  one-cycle pulse from the display reader at the start of each display frame.
- `wr_base_addr`  out  32  `FRAME_BASE_ADDR` driven to the writer.
- `wr_buf_idx`  out  2  buffer currently being written.
- `rd_base_addr`  out  32  base address driven to the reader.
- `rd_buf_idx`  out  2  buffer currently being displayed.
- `rd_valid`  out  1  set once the reader holds a committed frame.
- `frames_written`  out  16  number of committed frames; wraps at 65535 → 0.
- `frames_dropped`  out  16  number of overrun and timeout drops; wraps at 65535 → 0.
- `err_timeout`  out  1  sticky flag; cleared only by `rst`.
- `sched_state`  out  2  current state encoding.

## Operation
- State encodings: IDLE=0, ARM=1, WRITE=2, COMMIT=3.
- Frame edge: `fe = frame_done & ~frame_done_d1`. `frame_done_d1` is a register that resets to 0.
- Internal registers: `latest_idx` (2 bits) and `latest_valid`. They hold the newest committed buffer.
- IDLE → ARM when `enable` = 1.
- From any state, `enable` = 0 → IDLE on the next cycle. Indices, counters and flags hold. No commit occurs, even if `writer_done` arrives in the same cycle.
- ARM → WRITE on `fe`. The timer clears to 0. This aligns capture to a frame boundary.
- WRITE behaviour:
  - The timer increments every cycle.
  - `writer_done` → COMMIT.
  - A second `fe` with no `writer_done` is an overrun: `frames_dropped` +1, timer cleared, stay in WRITE on the same buffer.
  - Timer = `TIMEOUT_CYCLES`-1 with no `writer_done`: `err_timeout` ← 1, `frames_dropped` +1, → ARM with no publish.
  - `writer_done` and `fe` in the same cycle: `writer_done` wins and no drop is counted.
- COMMIT (one cycle):
  - `latest_idx` ← `wr_buf_idx`, `latest_valid` ← 1, `frames_written` +1.
  - `wr_buf_idx` ← lowest index in {0,1,2} that is ≠ `wr_buf_idx` and ≠ `rd_buf_idx_next`.
  - → WRITE, timer cleared. The writer restarts its own offset on `fe`.
- Reader swap, evaluated in every state:
  - Condition: `rd_frame_start` & `latest_valid` & (`latest_idx` ≠ `rd_buf_idx`).
  - Action: `rd_buf_idx` ← `latest_idx`, `rd_valid` ← 1.
  - `rd_buf_idx_next` is the value `rd_buf_idx` takes this cycle.
  - The swap uses the pre-COMMIT `latest_idx`.
- Invariant: `wr_buf_idx` ≠ `rd_buf_idx` at all times. `wr_buf_idx` ≠ `latest_idx` whenever `latest_valid` = 1.
- Address arithmetic: base = `BASE_ADDR` + idx×`FRAME_STRIDE`, computed as 32-bit unsigned modulo 2^32. Address outputs are registered and update in the same cycle as their index.

## Timing
- Reset values:
  - state IDLE; `wr_buf_idx`=0, `rd_buf_idx`=2.
  - `wr_base_addr`=`BASE_ADDR`; `rd_base_addr`=`BASE_ADDR`+2×`FRAME_STRIDE`.
  - `rd_valid`=0, `latest_valid`=0; counters 0; `err_timeout`=0; `sched_state`=0.
- `rst` takes priority over every other input in the same cycle. Reset mid-WRITE discards the frame uncounted.
- `frame_done` rises in cycle N → `fe` = 1 in N, so ARM→WRITE is seen in N+1.
- `writer_done` in cycle N (WRITE) → COMMIT in N+1 → new `wr_buf_idx`/`wr_base_addr` and `frames_written` visible in N+2.
- `rd_frame_start` in cycle N → `rd_buf_idx`/`rd_base_addr` valid in N+1.
- `wr_base_addr` changes only in the COMMIT cycle, so it is stable through the whole frame.

## Test plan
- Reset, then `enable`=1, `fe`, `writer_done` → COMMIT. Then `wr_buf_idx`=1, `wr_base_addr`=0x1004_0000, `frames_written`=1, `rd_valid`=0.
- Following the first commit, `rd_frame_start` → `rd_buf_idx`=0, `rd_base_addr`=0x1000_0000, `rd_valid`=1. The next COMMIT (writing 1, reader on 0) → `wr_buf_idx`=2.
- `rd_frame_start` and COMMIT in the same cycle, with reader on 2, `latest`=0, writing 1:
  - The reader takes 0.
  - The new write buffer is 2, since it is ≠ 1 and ≠ 0; the invariant holds.
- Two `fe` with no `writer_done` → `frames_dropped`=1, `wr_buf_idx` unchanged, `frames_written` unchanged.
- `TIMEOUT_CYCLES`=100 and no `writer_done` → at WRITE cycle 100: `err_timeout`=1, `frames_dropped`+1, state ARM. A subsequent `rst` clears everything to the reset values.
- `enable` dropped mid-WRITE together with `writer_done` → IDLE with no commit and indices held. On re-enable, ARM waits for the next `fe`.
